// File: rtl/serial_8bit_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_8bit_subtractor
//  Description : Bit-serial unsigned subtractor. A single full-subtractor
//                slice computes diff = a - b - bin one bit per cycle, LSB
//                first, behind a valid/ready handshake on each side.
//
//                Timing: the accept edge counts as edge 1. WIDTH further
//                edges shift the operands, and out_valid is visible after
//                edge WIDTH+1. The result is consumed on the next edge that
//                sees out_ready. A new accept is possible on the edge after
//                that. With out_ready held high, operations can issue every
//                WIDTH+2 cycles.
//
//  Ports       : clk        - clock, rising-edge active
//                rst_n      - synchronous active-low reset
//                in_valid   - a/b/bin valid
//                in_ready   - block can accept operands (IDLE only)
//                a, b       - minuend / subtrahend (WIDTH bits)
//                bin        - borrow-in
//                out_valid  - diff/bout valid
//                out_ready  - consumer accepts the result
//                diff       - difference (WIDTH bits)
//                bout       - borrow-out
//                busy       - subtraction in progress (SHIFT or DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_8bit_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_br;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_diff;
    logic              r_bout;
    logic              r_out_valid;
    logic              r_busy;

    // Full-subtractor slice on the current LSBs of the operand registers.
    logic              w_ai;
    logic              w_bi;
    logic              w_d;
    logic              w_br_next;
    logic [WIDTH:0]    w_diff_cat;

    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_d       = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~w_ai & r_br) | (w_bi & r_br);

    // New difference bit enters at the MSB side. After WIDTH shifts the
    // first (LSB) bit has reached position 0.
    assign w_diff_cat = {w_d, r_diff};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_br        <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_br   <= w_br_next;
                    r_diff <= w_diff_cat[WIDTH:1];
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_bout      <= w_br_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // The result registers stay untouched until consumed.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign busy      = r_busy;

endmodule
`default_nettype wire
